// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one shared multi-cycle resource: bounded hold time and a one-cycle turnaround between owners.
// Grant appears 1 cycle after req is sampled; res_ready gates new grants only and never revokes a current one.
module rr_resource_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int HOLD_MAX = 8,
  localparam int IDW      = $clog2(N_REQ),
  localparam int CNTW     = $clog2(HOLD_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic             res_ready,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [IDW-1:0]   gnt_id_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt;
  logic             timeout_nxt;

  logic             win_vld;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   cand;
  int               win_idx;

  // Scan from the far end back towards ptr so the candidate closest to ptr is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    win_idx = 0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      win_idx = int'(ptr) + k;
      if (win_idx >= N_REQ) win_idx = win_idx - N_REQ;
      cand = IDW'(win_idx);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    cnt_nxt     = cnt;
    ptr_nxt     = ptr;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, RELEASE: begin
        gnt_nxt = '0;
        if (win_vld && res_ready) begin
          state_nxt        = OWN;
          gnt_nxt[win_id]  = 1'b1;
          gnt_id_nxt       = win_id;
          cnt_nxt          = CNTW'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN: begin
        // ptr advances on leaving OWN, so the RELEASE cycle already arbitrates past the old owner.
        if (done[gnt_id] || !req[gnt_id]) begin
          state_nxt = RELEASE;
          gnt_nxt   = '0;
          ptr_nxt   = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);
        end else if (cnt == CNTW'(HOLD_MAX)) begin
          state_nxt   = RELEASE;
          gnt_nxt     = '0;
          ptr_nxt     = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // timeout is visible during the turnaround cycle in which the grant has been revoked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      cnt     <= '0;
      ptr     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_id  <= gnt_id_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      timeout <= timeout_nxt;
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed-vector bench for rr_resource_arbiter (N_REQ=4, HOLD_MAX=8).
module tb_rr_resource_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic       res_ready;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int nvec = 0;
  int nerr = 0;

  rr_resource_arbiter #(.N_REQ(4), .HOLD_MAX(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .res_ready (res_ready),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                         input logic e_to);
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(e_gnt != 4'b0000));
    chk({tag, ".timeout"}, 32'(timeout), 32'(e_to));
    if (e_gnt != 4'b0000) chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(e_id));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 4'b0000;
    done      = 4'b0000;
    res_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] oh;
    // Reset state
    do_reset();
    chk_out("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.gnt_id", 32'(gnt_id), 32'd0);

    // 1: req=0101, done[0] in the 3rd OWN cycle, then owner 2 after one gap cycle
    req = 4'b0101; res_ready = 1'b1;
    step(); chk_out("t1.own0_c1", 4'b0001, 2'd0, 1'b0);
    step(); chk_out("t1.own0_c2", 4'b0001, 2'd0, 1'b0);
    step(); chk_out("t1.own0_c3", 4'b0001, 2'd0, 1'b0);
    done = 4'b0001;
    step(); chk_out("t1.release", 4'b0000, 2'd0, 1'b0);
    done = 4'b0000;
    step(); chk_out("t1.own2", 4'b0100, 2'd2, 1'b0);

    // 2: all requesting, each owner holds exactly 8 cycles, timeout in the gap cycle
    do_reset();
    req = 4'b1111; res_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      oh = 4'b0001 << (n % 4);
      for (int c = 1; c <= 8; c++) begin
        step(); chk_out($sformatf("t2.o%0d_c%0d", n, c), oh, 2'(n % 4), 1'b0);
      end
      step(); chk_out($sformatf("t2.gap%0d", n), 4'b0000, 2'd0, 1'b1);
    end

    // 3: res_ready low blocks the grant; grant one cycle after it rises
    do_reset();
    req = 4'b0010; res_ready = 1'b0;
    step(); chk_out("t3.blocked1", 4'b0000, 2'd0, 1'b0);
    step(); chk_out("t3.blocked2", 4'b0000, 2'd0, 1'b0);
    res_ready = 1'b1;
    step(); chk_out("t3.granted", 4'b0010, 2'd1, 1'b0);
    res_ready = 1'b0;
    step(); chk_out("t3.held_ready_low", 4'b0010, 2'd1, 1'b0);

    // 4: done from a non-owner is ignored; owner dropping req releases without timeout
    do_reset();
    req = 4'b0101; res_ready = 1'b1;
    step(); chk_out("t4.own0", 4'b0001, 2'd0, 1'b0);
    done = 4'b0100;
    step(); chk_out("t4.foreign_done", 4'b0001, 2'd0, 1'b0);
    done = 4'b0000; req = 4'b0100;
    step(); chk_out("t4.release", 4'b0000, 2'd0, 1'b0);
    step(); chk_out("t4.own2", 4'b0100, 2'd2, 1'b0);

    // 5: done on the HOLD_MAX cycle wins over the timeout
    do_reset();
    req = 4'b0001; res_ready = 1'b1;
    for (int c = 1; c <= 8; c++) step();
    chk_out("t5.own0_c8", 4'b0001, 2'd0, 1'b0);
    done = 4'b0001;
    step(); chk_out("t5.release", 4'b0000, 2'd0, 1'b0);
    done = 4'b0000;
    step(); chk_out("t5.regrant", 4'b0001, 2'd0, 1'b0);

    // 6: async reset during ownership of requester 3, ptr back to 0 afterwards
    do_reset();
    req = 4'b1000; res_ready = 1'b1;
    step(); chk_out("t6.own3", 4'b1000, 2'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("t6.async_drop", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    step(); chk_out("t6.in_reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    step(); chk_out("t6.first_after_reset", 4'b0001, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
